// File: rtl/ram_rr_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous RAM, one operation in flight.
// Define RAM_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module ram_rr_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic                owner_q;
  logic                is_read_q;
  logic                gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, busy_q;
  logic                ram_en_q, ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q, rdata_q;
`ifndef RAM_ARB_FIXED_PRI_EN
  logic                last_grant_q;
`endif

  logic                win1_d;
  logic                win_we_d;
  logic [ADDR_W-1:0]   win_addr_d;
  logic [DATA_W-1:0]   win_wdata_d;

  // Winner selection and mux of the winning request fields.
  always_comb begin
    win1_d = 1'b0;
`ifdef RAM_ARB_FIXED_PRI_EN
    if (req0) begin
      win1_d = 1'b0;
    end else if (req1) begin
      win1_d = 1'b1;
    end else begin
      win1_d = 1'b0;
    end
`else
    if (req0 && req1) begin
      win1_d = ~last_grant_q;
    end else if (req1) begin
      win1_d = 1'b1;
    end else begin
      win1_d = 1'b0;
    end
`endif
    if (win1_d) begin
      win_we_d    = we1;
      win_addr_d  = addr1;
      win_wdata_d = wdata1;
    end else begin
      win_we_d    = we0;
      win_addr_d  = addr0;
      win_wdata_d = wdata0;
    end
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      is_read_q    <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      busy_q       <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rdata_q      <= '0;
`ifndef RAM_ARB_FIXED_PRI_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt0_q       <= ~win1_d;
            gnt1_q       <= win1_d;
            ram_en_q     <= 1'b1;
            ram_we_q     <= win_we_d;
            ram_addr_q   <= win_addr_d;
            ram_din_q    <= win_wdata_d;
            owner_q      <= win1_d;
            is_read_q    <= ~win_we_d;
`ifndef RAM_ARB_FIXED_PRI_EN
            last_grant_q <= win1_d;
`endif
            busy_q       <= 1'b1;
            state_q      <= CMD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CMD: begin
          // RAM samples the command at this edge; address/data stay as they were.
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          if (is_read_q) begin
            busy_q  <= 1'b1;
            state_q <= RESP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RESP: begin
          rdata_q   <= ram_dout;
          rvalid0_q <= ~owner_q;
          rvalid1_q <= owner_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_en   = ram_en_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule
